rx_frame_controller: RTL

RX_FRAME_CONTROLLER -- requirements
Module: rx_frame_controller

---
 rtl/rx_frame_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rx_frame_controller.sv
// Receive-side frame sequencer: arms on enable, then walks signal/preamble/Barker detection
// into frame reception under a shared wait timer, keeping frame and timeout statistics.
module rx_frame_controller #(
  parameter int TIMEOUT_WIDTH = 16,
  parameter int PD_TIMEOUT    = 1000,
  parameter int BD_TIMEOUT    = 200,
  parameter int FRAME_TIMEOUT = 40000,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 SD_in,
  input  logic                 PD_in,
  input  logic                 BD_in,
  input  logic                 BD_sgn_in,
  input  logic                 frame_done,
  output logic                 SD_flag,
  output logic                 PD_flag,
  output logic                 BD_flag,
  output logic                 BD_sgn,
  output logic                 det_clear,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] timeout_cnt
);

  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_WAIT_SD = 6'b000010,
    S_WAIT_PD = 6'b000100,
    S_WAIT_BD = 6'b001000,
    S_RECV    = 6'b010000,
    S_FLUSH   = 6'b100000
  } state_e;

  localparam logic [TIMEOUT_WIDTH-1:0] PD_LAST    = TIMEOUT_WIDTH'(PD_TIMEOUT - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] BD_LAST    = TIMEOUT_WIDTH'(BD_TIMEOUT - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] FRAME_LAST = TIMEOUT_WIDTH'(FRAME_TIMEOUT - 1);

  state_e                   state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
  logic                     sd_flag_q, sd_flag_d;
  logic                     pd_flag_q, pd_flag_d;
  logic                     bd_flag_q, bd_flag_d;
  logic                     bd_sgn_q, bd_sgn_d;
  logic                     det_clear_q, det_clear_d;
  logic                     busy_q, busy_d;
  logic [CNT_WIDTH-1:0]     frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0]     timeout_cnt_q, timeout_cnt_d;
  logic                     frame_inc, timeout_inc;

  always_comb begin
    state_d     = state_q;
    timer_d     = '0;
    pd_flag_d   = pd_flag_q;
    bd_flag_d   = 1'b0;
    bd_sgn_d    = bd_sgn_q;
    frame_inc   = 1'b0;
    timeout_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_WAIT_SD;
      end
      S_WAIT_SD: begin
        if (!enable)    state_d = S_IDLE;
        else if (SD_in) state_d = S_WAIT_PD;
      end
      // Detect wins over timeout in every wait state; a detect restarts the timer.
      S_WAIT_PD: begin
        timer_d = timer_q + 1'b1;
        if (PD_in) begin
          state_d   = S_WAIT_BD;
          pd_flag_d = 1'b1;
          timer_d   = '0;
        end else if (!SD_in) begin
          state_d = S_FLUSH;
        end else if (timer_q == PD_LAST) begin
          state_d     = S_FLUSH;
          timeout_inc = 1'b1;
        end
      end
      S_WAIT_BD: begin
        timer_d = timer_q + 1'b1;
        if (BD_in) begin
          state_d   = S_RECV;
          bd_flag_d = 1'b1;
          bd_sgn_d  = BD_sgn_in;
          timer_d   = '0;
        end else if (timer_q == BD_LAST) begin
          state_d     = S_FLUSH;
          timeout_inc = 1'b1;
        end
      end
      S_RECV: begin
        timer_d = timer_q + 1'b1;
        if (frame_done) begin
          state_d   = S_FLUSH;
          frame_inc = 1'b1;
        end else if (timer_q == FRAME_LAST) begin
          state_d     = S_FLUSH;
          timeout_inc = 1'b1;
        end
      end
      S_FLUSH: begin
        state_d = enable ? S_WAIT_SD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_FLUSH) pd_flag_d = 1'b0;
    sd_flag_d     = SD_in && (state_d != S_IDLE);
    det_clear_d   = (state_d == S_FLUSH);
    busy_d        = (state_d inside {S_WAIT_PD, S_WAIT_BD, S_RECV});
    frame_cnt_d   = (frame_inc && (frame_cnt_q != '1)) ? frame_cnt_q + 1'b1 : frame_cnt_q;
    timeout_cnt_d = (timeout_inc && (timeout_cnt_q != '1)) ? timeout_cnt_q + 1'b1 : timeout_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      sd_flag_q     <= 1'b0;
      pd_flag_q     <= 1'b0;
      bd_flag_q     <= 1'b0;
      bd_sgn_q      <= 1'b0;
      det_clear_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_cnt_q   <= '0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      sd_flag_q     <= sd_flag_d;
      pd_flag_q     <= pd_flag_d;
      bd_flag_q     <= bd_flag_d;
      bd_sgn_q      <= bd_sgn_d;
      det_clear_q   <= det_clear_d;
      busy_q        <= busy_d;
      frame_cnt_q   <= frame_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign SD_flag     = sd_flag_q;
  assign PD_flag     = pd_flag_q;
  assign BD_flag     = bd_flag_q;
  assign BD_sgn      = bd_sgn_q;
  assign det_clear   = det_clear_q;
  assign busy        = busy_q;
  assign frame_cnt   = frame_cnt_q;
  assign timeout_cnt = timeout_cnt_q;

endmodule
